// File: rtl/systolic_skew_feeder.sv
// Skews and zero-pads A-column / B-row slices into the diagonal streams a 16x16 systolic array expects,
// then sequences one K-slice tile and its drain. Optional stall counter: define SKEW_BUBBLE_CNT_EN.
module systolic_skew_feeder #(
    parameter int unsigned N  = 16,
    parameter int unsigned W  = 16,
    parameter int unsigned K  = 16,
    parameter int unsigned CW = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] a_in,
    input  logic [N*W-1:0] b_in,
    output logic [N*W-1:0] a_out,
    output logic [N*W-1:0] b_out,
    output logic           busy,
`ifdef SKEW_BUBBLE_CNT_EN
    output logic [15:0]    bubble_cnt,
`endif
    output logic           tile_done
);

    localparam int unsigned DRAIN_LAST = 3 * N - 2;
    localparam int unsigned LAST_SLICE = K - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_slice_cnt;
    logic [CW-1:0]   r_drain_cnt;
    logic            r_in_ready;
    logic            r_busy;
    logic            r_tile_done;
    logic            w_accept;

    assign w_accept = in_valid & r_in_ready;

    // Tile sequencer: collect K slices, wait for the array pipeline to settle, pulse done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_slice_cnt <= '0;
            r_drain_cnt <= '0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_tile_done <= 1'b0;
        end else begin
            r_tile_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_slice_cnt <= CW'(1);
                        r_busy      <= 1'b1;
                        if (K == 1) begin
                            r_state     <= S_DRAIN;
                            r_drain_cnt <= '0;
                            r_in_ready  <= 1'b0;
                        end else begin
                            r_state <= S_FEED;
                        end
                    end
                end
                S_FEED: begin
                    if (w_accept) begin
                        r_slice_cnt <= r_slice_cnt + CW'(1);
                        if (r_slice_cnt == CW'(LAST_SLICE)) begin
                            r_state     <= S_DRAIN;
                            r_drain_cnt <= '0;
                            r_in_ready  <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + CW'(1);
                    if (r_drain_cnt == CW'(DRAIN_LAST)) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_tile_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_slice_cnt <= '0;
                    r_drain_cnt <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign tile_done = r_tile_done;

    // Lane i: (i+1)-deep delay chain plus output register; idle cycles shift in zeros.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [W-1:0] r_a_dly [0:i];
        logic [W-1:0] r_b_dly [0:i];
        logic [W-1:0] r_a_out;
        logic [W-1:0] r_b_out;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int s = 0; s <= i; s++) begin
                    r_a_dly[s] <= '0;
                    r_b_dly[s] <= '0;
                end
                r_a_out <= '0;
                r_b_out <= '0;
            end else begin
                r_a_dly[0] <= w_accept ? a_in[i*W +: W] : '0;
                r_b_dly[0] <= w_accept ? b_in[i*W +: W] : '0;
                for (int s = 1; s <= i; s++) begin
                    r_a_dly[s] <= r_a_dly[s-1];
                    r_b_dly[s] <= r_b_dly[s-1];
                end
                r_a_out <= r_a_dly[i];
                r_b_out <= r_b_dly[i];
            end
        end

        assign a_out[i*W +: W] = r_a_out;
        assign b_out[i*W +: W] = r_b_out;
    end

`ifdef SKEW_BUBBLE_CNT_EN
    logic [15:0] r_bubble_cnt;

    // Mid-tile stall counter; restarts with each new tile, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bubble_cnt <= '0;
        end else if (r_state == S_IDLE && w_accept) begin
            r_bubble_cnt <= '0;
        end else if (r_state == S_FEED && !in_valid && r_bubble_cnt != 16'hFFFF) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
